// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch driver: FSM state encoding,
// synchronizer depth and a small max helper used for counter sizing.
package sr_drv_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_e;

  localparam int SYNC_STAGES = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/sr_sync2.sv
// Multi-flop synchronizer (SYNC_STAGES deep) for an asynchronous level input.
// Async active-high reset clears every stage to 0.
module sr_sync2
  import sr_drv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/sr_latch_driver.sv
// Drives S/R of an asynchronous SR latch with fixed-width pulses, then confirms Q.
// Optional macro SR_LATCH_DRV_SKIP_REDUNDANT_EN: skip the pulse when Q already matches.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic req_ready,
  output logic s_out,
  output logic r_out,
  input  logic q_in,
  output logic q_sync,
  output logic done,
  output logic err
);
  localparam int CNT_W = $clog2(max3(PULSE_W, GAP_W, TIMEOUT) + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_q, tgt_d;
  logic             s_q, s_d, r_q, r_d;
  logic             done_q, done_d, err_q, err_d, rdy_q, rdy_d;
  logic             q_s, skip;

  sr_sync2 u_sync (.clk(clk), .rst(rst), .d(q_in), .q(q_s));

`ifdef SR_LATCH_DRV_SKIP_REDUNDANT_EN
  assign skip = (set_req == q_s);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    s_d     = s_q;
    r_d     = r_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        // rdy_q gates acceptance so the cycle after done/err ignores requests
        if (rdy_q) begin
          if (set_req && clr_req) begin
            err_d = 1'b1;
          end else if (set_req ^ clr_req) begin
            tgt_d = set_req;
            rdy_d = 1'b0;
            if (skip) begin
              done_d = 1'b1;
            end else begin
              state_d = PULSE;
              cnt_d   = '0;
              s_d     = set_req;
              r_d     = ~set_req;
            end
          end
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(PULSE_W - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          s_d     = 1'b0;
          r_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_W - 1)) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (q_s == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign req_ready = rdy_q;
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign q_sync    = q_s;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_sr_latch_driver.sv
// Randomized bench for sr_latch_driver against a behavioural SR latch and a
// timeline model derived from pulse/gap/timeout arithmetic.
module tb_sr_latch_driver;
  localparam int PW = 2, GW = 1, TO = 8;

  logic clk = 1'b0, rst = 1'b1, set_req = 1'b0, clr_req = 1'b0;
  logic q_in, req_ready, s_out, r_out, q_sync, done, err;
  logic lq = 1'b0, stuck = 1'b0;
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  // behavioural latch; stuck forces the readback low regardless of drive
  always @(s_out, r_out) begin
    if (s_out)      lq = 1'b1;
    else if (r_out) lq = 1'b0;
  end
  assign q_in = stuck ? 1'b0 : lq;

  sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .req_ready(req_ready), .s_out(s_out), .r_out(r_out), .q_in(q_in),
    .q_sync(q_sync), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) chk("s_and_r", {31'd0, s_out & r_out}, 32'd0);

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic run_req(input logic s, input logic c, input bit noise);
    logic q0, reach, tgt;
    bit   redundant, exp_err;
    int   last;
    logic [4:0] exp_v;
    @(negedge clk);
    q0 = stuck ? 1'b0 : lq;
    chk("ready_idle", req_ready, 1'b1);
    set_req = s; clr_req = c;
    @(posedge clk); #1;
    set_req = 1'b0; clr_req = 1'b0;
    if (s == c) begin
      chk("no_req_or_illegal", {s_out, r_out, req_ready, done, err},
          {1'b0, 1'b0, 1'b1, 1'b0, s & c});
      @(posedge clk); #1;
      chk("idle_after", {s_out, r_out, req_ready, done, err}, 5'b00100);
      return;
    end
    tgt = s;
    redundant = 1'b0;
`ifdef SR_LATCH_DRV_SKIP_REDUNDANT_EN
    redundant = (tgt == q0);
`endif
    reach   = stuck ? 1'b0 : tgt;
    exp_err = !redundant && (reach != tgt);
    last    = redundant ? 0 : (exp_err ? PW + GW + TO : PW + GW + 1);
    for (int i = 0; i <= last; i++) begin
      exp_v = {(!redundant && i < PW) & tgt, (!redundant && i < PW) & ~tgt, 1'b0,
               (i == last) && !exp_err, (i == last) && exp_err};
      chk($sformatf("seq_t%0d_c%0d", tgt, i), {s_out, r_out, req_ready, done, err}, exp_v);
      if (noise) begin set_req = 1'($urandom); clr_req = 1'($urandom); end
      @(posedge clk); #1;
    end
    set_req = 1'b0; clr_req = 1'b0;
    chk("ready_back", {req_ready, done, err}, 3'b100);
    chk("q_sync_end", q_sync, redundant ? q0 : reach);
  endtask

  initial begin
    int kind;
    #2;
    chk("rst_outs", {s_out, r_out, req_ready, done, err, q_sync}, 6'b0);
    @(negedge clk); rst = 1'b0;
    #1 chk("ready_before_edge", req_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_first_edge", req_ready, 1'b1);

    run_req(1'b1, 1'b0, 1'b0);
    run_req(1'b0, 1'b1, 1'b0);
    run_req(1'b1, 1'b1, 1'b0);
    stuck = 1'b1;
    run_req(1'b1, 1'b0, 1'b0);
    stuck = 1'b0;
    idle(3);
    run_req(1'b0, 1'b1, 1'b0);

    // reset during the second pulse cycle
    @(negedge clk); set_req = 1'b1;
    @(posedge clk); #1; set_req = 1'b0;
    chk("mid_pulse1", s_out, 1'b1);
    @(posedge clk); #1;
    chk("mid_pulse2", s_out, 1'b1);
    rst = 1'b1;
    #1 chk("rst_mid", {s_out, r_out, req_ready, done, err, q_sync}, 6'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", req_ready, 1'b1);
    idle(3);
    run_req(1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      stuck = ($urandom_range(0, 3) == 0);
      idle(3);
      kind = int'($urandom_range(0, 3));
      run_req(kind[0], kind[1], 1'b1);
    end
    stuck = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
